stream_perf_monitor: RTL and testbench
======================================

// Module: stream_perf_monitor
// PURPOSE
//  Multi-channel successor to the single-stream handshake monitor: observes NUM_CH valid/ready/last
//  streams passively and keeps per-channel transfer, in-frame cycle, stall and frame counters.
//  On request, freezes all counters into a shadow bank and drains it over a ready/valid readout
//  stream, so throughput figures are read by logic rather than printed by the testbench.
// PARAMETERS
//  NUM_CH     4   number of monitored streams (>=1)
//  CNT_W      32  width of every counter and of out_data (>=8)
//  SATURATE   1   1: counters stick at all-ones; 0: counters wrap to 0
// PORTS
//  clk        in   1             clock; all monitored streams are synchronous to it
//  rst_n      in   1             reset, asynchronous, active-high
//  mon_valid  in   NUM_CH        per-channel valid of the observed stream
//  mon_ready  in   NUM_CH        per-channel ready of the observed stream
//  mon_last   in   NUM_CH        per-channel last of the observed stream
//  clear      in   1             synchronous clear of all live counters and frame states
//  snap_req   in   1             capture live counters into shadow bank and start readout
//  snap_busy  out  1             high from the capture cycle until the final readout word is accepted
//  out_valid  out  1             readout word valid
//  out_ready  in   1             readout word accepted
//  out_data   out  CNT_W         readout counter value
//  out_ch     out  clog2(NUM_CH) channel of out_data (1 bit minimum)
//  out_field  out  2             0=xfer 1=active 2=stall 3=frame
//  out_last   out  1             high on the final word (ch NUM_CH-1, field 3)
// BEHAVIOUR
//  Reset: all live and shadow counters 0, all frame states IDLE, readout state R_IDLE,
//   snap_busy/out_valid/out_last 0, out_data/out_ch/out_field 0.
//  Per channel c, hs = mon_valid[c] & mon_ready[c]:
//   - xfer   +1 on every hs.
//   - frame  +1 on hs & mon_last[c].
//   - stall  +1 on mon_valid[c] & ~mon_ready[c], in any frame state.
//   - active +1 every cycle where fstate==IN_FRAME, or where hs occurs in IDLE.
//   - fstate: IDLE->IN_FRAME on hs & ~last; IN_FRAME->IDLE on hs & last; single-beat frame
//     (hs & last in IDLE) stays IDLE but still counts 1 active cycle and 1 frame.
//  Width rule: increments are +1 per cycle max; SATURATE=1 holds all-ones, SATURATE=0 wraps.
//  clear: all live counters <=0 and fstate<=IDLE next edge; the clear-cycle event is not counted.
//   Shadow bank and readout unaffected by clear.
//  Readout FSM:
//   R_IDLE: snap_req -> shadow <= live register values (pre-increment of that cycle),
//     go R_DUMP, snap_busy<=1, out_valid<=1, word index 0. Live counters keep counting
//     (or clear, if clear is also high: shadow gets pre-clear values).
//   R_DUMP: words ordered ch0 f0..f3, ch1 f0..f3, ... ; index advances only on
//     out_valid & out_ready; out_data/out_ch/out_field/out_last stable while stalled.
//     On acceptance of out_last word: out_valid<=0, snap_busy<=0, out_last<=0 -> R_IDLE.
//   snap_req ignored while snap_busy=1 (no re-capture, no queueing).
//   Output registers are updated from shadow one cycle after index change; out_valid never
//     asserts with stale data (first word valid in cycle after capture).
//  Latency: capture edge -> out_valid=1 after 1 clk; full dump minimum 4*NUM_CH cycles.
//  Monitor never drives the observed streams; reset mid-dump aborts readout to reset values.
// TESTING
//  1 ch0: 5-beat frame, ready always 1 (last on beat 5), then snap, out_ready=1
//    -> ch0 words xfer=5 active=5 stall=0 frame=1; other channels all 0; 16 words, last on 16th.
//  2 ch1: valid=1 ready low for 3 cycles then 2 beats (last on 2nd) -> stall=3 xfer=2 frame=1 active=2.
//  3 ch2: three single-beat frames (last every beat) -> xfer=3 frame=3 active=3, fstate stays IDLE.
//  4 snap with out_ready toggling 1/0 each cycle -> 16 words, each held unchanged while stalled;
//    snap_req pulsed mid-dump -> ignored, dump sequence unchanged, snap_busy drops after word 16.
//  5 CNT_W=8, SATURATE=1: 300 beats on ch3 -> xfer=255; SATURATE=0 -> xfer=44.
//  6 clear and snap_req same cycle after 7 beats -> readout shows xfer=7; next snap shows 0 plus
//    only post-clear beats; assert rst_n mid-dump -> out_valid=0, snap_busy=0 next cycle.

Source files
------------

// File: rtl/stream_perf_monitor.sv
// Passively counts per-channel transfers, in-frame cycles, stalls and frames; snapshots them for readout.
// Latency: capture edge -> out_valid after 1 clk; one word per accepted cycle (4*NUM_CH words minimum).
// Backpressure: readout holds out_* stable while out_ready is low; monitored streams are never driven.
module stream_perf_monitor #(
  parameter  int NUM_CH   = 4,
  parameter  int CNT_W    = 32,
  parameter  int SATURATE = 1,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] mon_valid,
  input  logic [NUM_CH-1:0] mon_ready,
  input  logic [NUM_CH-1:0] mon_last,
  input  logic              clear,
  input  logic              snap_req,
  output logic              snap_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [1:0]        out_field,
  output logic              out_last
);

  localparam int NWORDS = 4 * NUM_CH;
  localparam int IDX_W  = $clog2(NWORDS);

  typedef enum logic {F_IDLE, F_IN_FRAME} fstate_e;
  typedef enum logic {R_IDLE, R_DUMP}     rstate_e;

  // Saturating or wrapping +1, chosen at elaboration.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if ((&v) && (SATURATE != 0)) return v;
    return v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] xfer_q  [NUM_CH];
  logic [CNT_W-1:0] xfer_d  [NUM_CH];
  logic [CNT_W-1:0] act_q   [NUM_CH];
  logic [CNT_W-1:0] act_d   [NUM_CH];
  logic [CNT_W-1:0] stall_q [NUM_CH];
  logic [CNT_W-1:0] stall_d [NUM_CH];
  logic [CNT_W-1:0] frm_q   [NUM_CH];
  logic [CNT_W-1:0] frm_d   [NUM_CH];
  fstate_e          fst_q   [NUM_CH];
  fstate_e          fst_d   [NUM_CH];

  logic [CNT_W-1:0] shd_q [NWORDS];
  rstate_e          rst_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] nidx;
  logic             snap_busy_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [CNT_W-1:0] out_data_q;
  logic [CH_W-1:0]  out_ch_q;
  logic [1:0]       out_field_q;

  assign nidx      = idx_q + IDX_W'(1);
  assign snap_busy = snap_busy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_field = out_field_q;

  // Next-state of live counters and frame trackers; clear wins over any event that cycle.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      xfer_d[c]  = xfer_q[c];
      act_d[c]   = act_q[c];
      stall_d[c] = stall_q[c];
      frm_d[c]   = frm_q[c];
      fst_d[c]   = fst_q[c];
      if (clear) begin
        xfer_d[c]  = '0;
        act_d[c]   = '0;
        stall_d[c] = '0;
        frm_d[c]   = '0;
        fst_d[c]   = F_IDLE;
      end else begin
        if (mon_valid[c] && mon_ready[c]) begin
          xfer_d[c] = bump(xfer_q[c]);
          if (mon_last[c]) begin
            frm_d[c] = bump(frm_q[c]);
            fst_d[c] = F_IDLE;
          end else begin
            fst_d[c] = F_IN_FRAME;
          end
        end
        if (mon_valid[c] && !mon_ready[c]) stall_d[c] = bump(stall_q[c]);
        // A single-beat frame in IDLE still occupies one active cycle.
        if ((fst_q[c] == F_IN_FRAME) || (mon_valid[c] && mon_ready[c])) act_d[c] = bump(act_q[c]);
      end
    end
  end

  // Live counter and frame-state registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        xfer_q[c]  <= '0;
        act_q[c]   <= '0;
        stall_q[c] <= '0;
        frm_q[c]   <= '0;
        fst_q[c]   <= F_IDLE;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        xfer_q[c]  <= xfer_d[c];
        act_q[c]   <= act_d[c];
        stall_q[c] <= stall_d[c];
        frm_q[c]   <= frm_d[c];
        fst_q[c]   <= fst_d[c];
      end
    end
  end

  // Readout FSM: capture into shadow bank, then stream words; word 0 is loaded at capture.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int w = 0; w < NWORDS; w++) shd_q[w] <= '0;
      rst_q       <= R_IDLE;
      idx_q       <= '0;
      snap_busy_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_field_q <= '0;
    end else begin
      case (rst_q)
        R_IDLE: begin
          if (snap_req) begin
            for (int c = 0; c < NUM_CH; c++) begin
              shd_q[4*c+0] <= xfer_q[c];
              shd_q[4*c+1] <= act_q[c];
              shd_q[4*c+2] <= stall_q[c];
              shd_q[4*c+3] <= frm_q[c];
            end
            rst_q       <= R_DUMP;
            idx_q       <= '0;
            snap_busy_q <= 1'b1;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            out_data_q  <= xfer_q[0];
            out_ch_q    <= '0;
            out_field_q <= '0;
          end
        end
        R_DUMP: begin
          if (out_valid_q && out_ready) begin
            if (out_last_q) begin
              rst_q       <= R_IDLE;
              snap_busy_q <= 1'b0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              idx_q       <= nidx;
              out_data_q  <= shd_q[nidx];
              out_ch_q    <= CH_W'(nidx >> 2);
              out_field_q <= nidx[1:0];
              out_last_q  <= (nidx == IDX_W'(NWORDS - 1));
            end
          end
        end
        default: rst_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_perf_monitor.sv
// Directed bench for stream_perf_monitor: counting rules, readout ordering/backpressure, clear, reset.
// Latency: n/a (testbench).
// Backpressure: bench drives out_ready steady or toggling to exercise readout stalls.
module tb_stream_perf_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  mon_valid, mon_ready, mon_last;
  logic        clear, snap_req, out_ready;
  logic        snap_busy, out_valid, out_last;
  logic [31:0] out_data;
  logic [1:0]  out_ch, out_field;

  logic [3:0]  m8_valid, m8_ready, m8_last;
  logic        clr8, snap8, rdy8;
  logic        s_busy, s_vld, s_last, w_busy, w_vld, w_last;
  logic [7:0]  s_data, w_data;
  logic [1:0]  s_ch, s_field, w_ch, w_field;

  stream_perf_monitor #(.NUM_CH(4), .CNT_W(32), .SATURATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
    .clear(clear), .snap_req(snap_req), .snap_busy(snap_busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch), .out_field(out_field),
    .out_last(out_last));

  stream_perf_monitor #(.NUM_CH(4), .CNT_W(8), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mon_valid(m8_valid), .mon_ready(m8_ready), .mon_last(m8_last),
    .clear(clr8), .snap_req(snap8), .snap_busy(s_busy), .out_valid(s_vld),
    .out_ready(rdy8), .out_data(s_data), .out_ch(s_ch), .out_field(s_field),
    .out_last(s_last));

  stream_perf_monitor #(.NUM_CH(4), .CNT_W(8), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .mon_valid(m8_valid), .mon_ready(m8_ready), .mon_last(m8_last),
    .clear(clr8), .snap_req(snap8), .snap_busy(w_busy), .out_valid(w_vld),
    .out_ready(rdy8), .out_data(w_data), .out_ch(w_ch), .out_field(w_field),
    .out_last(w_last));

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] ew [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] r, input logic [3:0] l);
    mon_valid = v; mon_ready = r; mon_last = l;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    mon_valid = '0; mon_ready = '0; mon_last = '0;
    repeat (n) @(negedge clk);
  endtask

  // Snap (optionally with clear / ch3 traffic), then drain 16 words against ew[].
  task automatic dump(input string tag, input bit toggle, input bit poke, input bit clr);
    int          words = 0;
    int          cyc = 0;
    bit          hold_pend = 1'b0;
    logic [63:0] held, cur, exp;
    logic [1:0]  wch, wfld;
    snap_req = 1'b1; clear = clr; out_ready = 1'b0;
    if (poke) begin mon_valid[3] = 1'b1; mon_ready[3] = 1'b1; mon_last[3] = 1'b0; end
    @(negedge clk);
    snap_req = 1'b0; clear = 1'b0;
    if (!poke) begin mon_valid = '0; mon_ready = '0; mon_last = '0; end
    check({tag, "_busy_on"}, snap_busy, 1);
    check({tag, "_valid_on"}, out_valid, 1);
    while (words < 16 && cyc < 200) begin
      cur = {27'd0, out_ch, out_field, out_last, out_data};
      if (hold_pend) check($sformatf("%s_hold%0d", tag, words), cur, held);
      out_ready = toggle ? ~cyc[0] : 1'b1;
      snap_req  = poke && (words == 5);
      if (out_valid && out_ready) begin
        wch  = words[3:2];
        wfld = words[1:0];
        exp  = {27'd0, wch, wfld, (words == 15), ew[words]};
        check($sformatf("%s_w%0d", tag, words), cur, exp);
        words++;
        hold_pend = 1'b0;
      end else if (out_valid) begin
        held = cur;
        hold_pend = 1'b1;
      end else begin
        hold_pend = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0; snap_req = 1'b0;
    check({tag, "_nwords"}, words, 16);
    check({tag, "_busy_off"}, snap_busy, 0);
    check({tag, "_valid_off"}, out_valid, 0);
  endtask

  initial begin
    int k, cyc;
    rst_n = 1'b1;
    mon_valid = '0; mon_ready = '0; mon_last = '0;
    clear = 1'b0; snap_req = 1'b0; out_ready = 1'b0;
    m8_valid = '0; m8_ready = '0; m8_last = '0;
    clr8 = 1'b0; snap8 = 1'b0; rdy8 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", snap_busy, 0);
    check("rst_word", {out_ch, out_field, out_last, out_data}, 0);
    rst_n = 1'b0;
    @(negedge clk);

    // ch0 5-beat frame
    for (int i = 0; i < 5; i++) drive(4'b0001, 4'b0001, (i == 4) ? 4'b0001 : 4'b0000);
    idle(1);
    ew = '{5, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    dump("t1", 1'b0, 1'b0, 1'b0);

    // ch1 3 stall cycles then 2 beats; ch2 three single-beat frames
    repeat (3) drive(4'b0010, 4'b0000, 4'b0000);
    drive(4'b0010, 4'b0010, 4'b0000);
    drive(4'b0010, 4'b0010, 4'b0010);
    idle(1);
    repeat (3) drive(4'b0100, 4'b0100, 4'b0100);
    idle(2);
    ew = '{5, 5, 0, 1, 2, 2, 3, 1, 3, 3, 0, 3, 0, 0, 0, 0};
    dump("t23", 1'b0, 1'b0, 1'b0);

    // toggling out_ready, ignored snap mid-dump while ch3 keeps counting
    dump("t4", 1'b1, 1'b1, 1'b0);
    idle(1);

    // clear, 7 beats in-frame, then clear+snap together (the 8th beat is dropped)
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    repeat (7) drive(4'b0001, 4'b0001, 4'b0000);
    ew = '{7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    dump("t6a", 1'b0, 1'b0, 1'b1);
    drive(4'b0001, 4'b0001, 4'b0000);
    drive(4'b0001, 4'b0001, 4'b0000);
    drive(4'b0001, 4'b0001, 4'b0001);
    idle(1);
    ew = '{3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    dump("t6b", 1'b0, 1'b0, 1'b0);

    // reset in the middle of a stalled dump
    snap_req = 1'b1; @(negedge clk); snap_req = 1'b0;
    out_ready = 1'b0; @(negedge clk);
    check("t6_pre_rst_valid", out_valid, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", snap_busy, 0);
    rst_n = 1'b0;
    @(negedge clk);
    ew = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    dump("t6c", 1'b0, 1'b0, 1'b0);

    // 8-bit counters: 300 beats on ch3, saturate vs wrap
    m8_valid = 4'b1000; m8_ready = 4'b1000;
    repeat (300) @(negedge clk);
    m8_valid = '0; m8_ready = '0;
    snap8 = 1'b1; @(negedge clk); snap8 = 1'b0; rdy8 = 1'b1;
    k = 0; cyc = 0;
    while (k < 16 && cyc < 100) begin
      if (s_vld) begin
        check($sformatf("t5_sat_w%0d", k), s_data, (k == 12 || k == 13) ? 255 : 0);
        check($sformatf("t5_wrap_w%0d", k), w_data, (k == 12 || k == 13) ? 44 : 0);
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    rdy8 = 1'b0;
    check("t5_nwords", k, 16);
    check("t5_sat_busy_off", s_busy, 0);
    check("t5_wrap_busy_off", w_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
